tc_pl_cap_data_cap_resp: RTL

TC_PL_CAP_DATA_CAP_RESP -- requirements
Module: tc_pl_cap_data_cap_resp

---
 rtl/tc_pl_cap_data_cap_resp.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/tc_pl_cap_data_cap_resp.sv
// ---------------------------------------------------------------------------
// tc_pl_cap_data_cap_resp
//
// Capture responder. The initiator raises Gc_cap_trig and holds it until it
// sees the one-cycle Gc_capr_rdy acknowledge. On a fresh rising edge of the
// trigger the block latches the phase tag and the sample count, acknowledges,
// and then forwards exactly that many qualified ADC samples. The final sample
// is marked with cap_last, and cap_done pulses in the same cycle. A trigger
// edge that arrives while a capture is already running is dropped and
// recorded in a sticky error flag.
//
// Timing, counted from the cycle in which Gc_cap_trig first shows high at the
// input:
//   +1 edge : rising edge detected, phase and count latched, FSM -> ACK
//   +2      : Gc_capr_rdy = 1 (one cycle), cap_busy rises
//   CAPT    : each adc_valid beat reappears one cycle later on cap_data
// A zero-length request acknowledges and then pulses cap_done in the cycle
// after Gc_capr_rdy, without forwarding any sample.
//
// Ports
//   clk            in   single rising-edge clock
//   rst            in   synchronous, active-high reset
//   Gc_cap_trig    in   capture request (level, held until acknowledged)
//   Gc_cap_phase   in   phase tag for the requested capture
//   cap_sample_num in   samples per capture, latched at request
//   adc_data       in   ADC sample
//   adc_valid      in   qualifies adc_data
//   Gc_capr_rdy    out  one-cycle capture-accepted acknowledge
//   cap_data       out  forwarded sample
//   cap_valid      out  qualifies cap_data
//   cap_last       out  marks the final sample of a capture
//   cap_phase      out  latched phase tag of the current capture
//   cap_busy       out  high while the FSM is in ACK or CAPT
//   cap_done       out  one-cycle pulse when a capture finishes
//   trig_ovr_err   out  sticky: a trigger edge was dropped
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module tc_pl_cap_data_cap_resp #(
  parameter int unsigned CAP0_3 = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Gc_cap_trig,
  input  logic [CAP0_3-1:0] Gc_cap_phase,
  input  logic [LEN_W-1:0]  cap_sample_num,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              Gc_capr_rdy,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid,
  output logic              cap_last,
  output logic [CAP0_3-1:0] cap_phase,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              trig_ovr_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck  = 2'd1,
    StCapt = 2'd2
  } state_e;

  state_e              state_q, state_d;

  // Delayed copy of the trigger used for edge detection.
  logic                trig_dly_q, trig_dly_d;
  // Low for the first edge after reset so a trigger that is already high
  // when reset releases only loads trig_dly_q and never looks like an edge.
  logic                arm_q, arm_d;

  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    sample_cnt_q, sample_cnt_d;

  // Zero-length capture: delays cap_done to the cycle after the acknowledge.
  logic                zero_done_q, zero_done_d;

  // Output registers.
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_valid_q, cap_valid_d;
  logic                cap_last_q, cap_last_d;
  logic [CAP0_3-1:0]   cap_phase_q, cap_phase_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                trig_rise;
  logic                accept;
  logic                last_beat;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    trig_dly_d   = Gc_cap_trig;
    arm_d        = 1'b1;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    zero_done_d  = 1'b0;
    cap_phase_d  = cap_phase_q;
    cap_data_d   = cap_data_q;

    trig_rise = arm_q & Gc_cap_trig & ~trig_dly_q;
    accept    = (state_q == StCapt) & adc_valid;
    last_beat = accept & (sample_cnt_q == (len_q - LEN_W'(1)));

    // Outputs are decoded from the current state and registered, so they
    // trail the FSM by one cycle.
    rdy_d       = (state_q == StAck);
    busy_d      = (state_q != StIdle);
    cap_valid_d = accept;
    cap_last_d  = last_beat;
    done_d      = last_beat | zero_done_q;
    ovr_d       = ovr_q | (trig_rise & (state_q != StIdle));

    if (accept) begin
      cap_data_d = adc_data;
    end

    unique case (state_q)
      StIdle: begin
        if (trig_rise) begin
          cap_phase_d  = Gc_cap_phase;
          len_d        = cap_sample_num;
          sample_cnt_d = '0;
          state_d      = StAck;
        end
      end
      StAck: begin
        if (len_q != '0) begin
          state_d = StCapt;
        end else begin
          zero_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StCapt: begin
        if (accept) begin
          sample_cnt_d = sample_cnt_q + LEN_W'(1);
          if (last_beat) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      trig_dly_q   <= 1'b0;
      arm_q        <= 1'b0;
      len_q        <= '0;
      sample_cnt_q <= '0;
      zero_done_q  <= 1'b0;
      rdy_q        <= 1'b0;
      cap_data_q   <= '0;
      cap_valid_q  <= 1'b0;
      cap_last_q   <= 1'b0;
      cap_phase_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_dly_q   <= trig_dly_d;
      arm_q        <= arm_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      zero_done_q  <= zero_done_d;
      rdy_q        <= rdy_d;
      cap_data_q   <= cap_data_d;
      cap_valid_q  <= cap_valid_d;
      cap_last_q   <= cap_last_d;
      cap_phase_q  <= cap_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
    end
  end

  assign Gc_capr_rdy  = rdy_q;
  assign cap_data     = cap_data_q;
  assign cap_valid    = cap_valid_q;
  assign cap_last     = cap_last_q;
  assign cap_phase    = cap_phase_q;
  assign cap_busy     = busy_q;
  assign cap_done     = done_q;
  assign trig_ovr_err = ovr_q;

endmodule
